// File: rtl/sched_pkg.sv
// ============================================================================
// Module  : sched_pkg
// Brief   : Shared constants, width helper and types for the schedule sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package sched_pkg;

    localparam int unsigned PHASE_HOME   = 0;
    localparam int unsigned DUR_RESET    = 1;
    localparam int unsigned N_PHASES_DEF = 4;
    localparam int unsigned DUR_W_DEF    = 8;

    // Index width for a table of n entries; never narrower than one bit.
    function automatic int unsigned ph_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef logic [ph_w(N_PHASES_DEF)-1:0] phase_t;
    typedef logic [DUR_W_DEF-1:0]          dur_t;

endpackage

`default_nettype wire

// File: rtl/sched_dur_table.sv
// ============================================================================
// Module  : sched_dur_table
// Brief   : Per-phase duration register file, one write port, async read port.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sched_dur_table
    import sched_pkg::*;
#(
    parameter  int unsigned N_PHASES = N_PHASES_DEF,
    parameter  int unsigned DUR_W    = DUR_W_DEF,
    localparam int unsigned PH_W     = ph_w(N_PHASES)
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             we_i,
    input  logic [PH_W-1:0]  wr_idx_i,
    input  logic [DUR_W-1:0] wr_dur_i,
    input  logic [PH_W-1:0]  rd_idx_i,
    output logic [DUR_W-1:0] rd_dur_o
);

    logic [DUR_W-1:0] dur_q [N_PHASES];

    // Matching by entry number drops writes aimed beyond the last phase.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int i = 0; i < N_PHASES; i++) begin
                dur_q[i] <= DUR_W'(DUR_RESET);
            end
        end else if (we_i) begin
            for (int i = 0; i < N_PHASES; i++) begin
                if (wr_idx_i == PH_W'(i)) begin
                    dur_q[i] <= wr_dur_i;
                end
            end
        end
    end

    assign rd_dur_o = dur_q[rd_idx_i];

endmodule

`default_nettype wire

// File: rtl/schedule_sequencer.sv
// ============================================================================
// Module  : schedule_sequencer
// Brief   : N-phase daily sequencer with programmable per-phase dwell and day
//           counter. Optional weekend tracking under SCHED_WEEKEND_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module schedule_sequencer
    import sched_pkg::*;
#(
    parameter  int unsigned N_PHASES  = N_PHASES_DEF,
    parameter  int unsigned DUR_W     = DUR_W_DEF,
    parameter  int unsigned DAY_W     = 16,
`ifdef SCHED_WEEKEND_EN
    parameter  int unsigned WEEK_LEN  = 7,
    parameter  int unsigned WORK_DAYS = 5,
`endif
    localparam int unsigned PH_W      = ph_w(N_PHASES)
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             en,
    input  logic             skip,
    input  logic             cfg_we,
    input  logic [PH_W-1:0]  cfg_idx,
    input  logic [DUR_W-1:0] cfg_dur,
    output logic [PH_W-1:0]  phase,
    output logic             home,
    output logic             phase_start,
    output logic             day_done,
`ifdef SCHED_WEEKEND_EN
    output logic             weekend,
`endif
    output logic [DAY_W-1:0] day_cnt
);

    logic [PH_W-1:0]  phase_q, phase_d;
    logic [DUR_W-1:0] cnt_q, cnt_d;
    logic [DAY_W-1:0] day_cnt_q, day_cnt_d;
    logic             home_q, home_d;
    logic             phase_start_q, phase_start_d;
    logic             day_done_q, day_done_d;

    logic [DUR_W-1:0] w_dur;
    logic [DUR_W-1:0] w_dur_m1;
    logic             w_last;
    logic             w_end;

    sched_dur_table #(
        .N_PHASES (N_PHASES),
        .DUR_W    (DUR_W)
    ) u_dur_table (
        .clk      (clk),
        .rst_     (rst_),
        .we_i     (cfg_we),
        .wr_idx_i (cfg_idx),
        .wr_dur_i (cfg_dur),
        .rd_idx_i (phase_q),
        .rd_dur_o (w_dur)
    );

    // A zero duration behaves as one cycle.
    assign w_dur_m1 = (w_dur == '0) ? '0 : w_dur - 1'b1;
    assign w_last   = (phase_q == PH_W'(N_PHASES - 1));
    assign w_end    = skip | (cnt_q >= w_dur_m1);

`ifdef SCHED_WEEKEND_EN
    localparam int unsigned WD_W = ph_w(WEEK_LEN);
    logic [WD_W-1:0] week_day_q, week_day_d;
    logic            weekend_q, weekend_d;
`endif

    always_comb begin
        phase_d       = phase_q;
        cnt_d         = cnt_q;
        day_cnt_d     = day_cnt_q;
        phase_start_d = 1'b0;
        day_done_d    = 1'b0;
`ifdef SCHED_WEEKEND_EN
        week_day_d    = week_day_q;
`endif
        if (en) begin
            if (w_end) begin
                phase_d       = w_last ? '0 : phase_q + 1'b1;
                cnt_d         = '0;
                phase_start_d = 1'b1;
                day_done_d    = w_last;
                if (w_last) begin
                    day_cnt_d = day_cnt_q + 1'b1;
`ifdef SCHED_WEEKEND_EN
                    week_day_d = (week_day_q == WD_W'(WEEK_LEN - 1)) ? '0 : week_day_q + 1'b1;
`endif
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // home is derived from the next phase so it lines up with the phase output.
        home_d = (phase_d == PH_W'(PHASE_HOME));
`ifdef SCHED_WEEKEND_EN
        weekend_d = (week_day_d >= WD_W'(WORK_DAYS));
        home_d    = home_d | weekend_d;
`endif
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            phase_q       <= PH_W'(PHASE_HOME);
            cnt_q         <= '0;
            day_cnt_q     <= '0;
            home_q        <= 1'b1;
            phase_start_q <= 1'b0;
            day_done_q    <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            cnt_q         <= cnt_d;
            day_cnt_q     <= day_cnt_d;
            home_q        <= home_d;
            phase_start_q <= phase_start_d;
            day_done_q    <= day_done_d;
        end
    end

`ifdef SCHED_WEEKEND_EN
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            week_day_q <= '0;
            weekend_q  <= 1'b0;
        end else begin
            week_day_q <= week_day_d;
            weekend_q  <= weekend_d;
        end
    end

    assign weekend = weekend_q;
`endif

    assign phase       = phase_q;
    assign home        = home_q;
    assign phase_start = phase_start_q;
    assign day_done    = day_done_q;
    assign day_cnt     = day_cnt_q;

endmodule

`default_nettype wire
